// File: rtl/tt_pkg.sv
// Shared state encoding and default sizes for the truth-table sweep/capture block.
// Tables are stored with bit i = f(minterm i), so the MSB (minterm TT_BITS-1) prints as the first hex digit.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    localparam int NUM_VARS_DEFAULT = 7;
    localparam int TT_BITS_DEFAULT  = 2 ** NUM_VARS_DEFAULT;

endpackage

// File: rtl/tt_lat_pipe.sv
// LAT-stage {valid, idx} delay line that tracks minterms through the function under test.
// With LAT=0 it collapses to plain wires.
module tt_lat_pipe #(
    parameter int LAT   = 0,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             vld_p0,
    input  logic [IDX_W-1:0] idx_p0,
    output logic             vld_out,
    output logic [IDX_W-1:0] idx_out
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_pipe;
            assign unused_pipe = ^{clk, rst_n, flush};
            assign vld_out     = vld_p0;
            assign idx_out     = idx_p0;
        end else begin : g_pipe
            logic             vld_p [1:LAT];
            logic [IDX_W-1:0] idx_p [1:LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || flush) begin
                    for (int i = 1; i <= LAT; i++) begin
                        vld_p[i] <= 1'b0;
                        idx_p[i] <= '0;
                    end
                end else begin
                    // stage p0 -> p1 ... p(LAT-1) -> pLAT
                    vld_p[1] <= vld_p0;
                    idx_p[1] <= idx_p0;
                    for (int i = 2; i <= LAT; i++) begin
                        vld_p[i] <= vld_p[i-1];
                        idx_p[i] <= idx_p[i-1];
                    end
                end
            end

            assign vld_out = vld_p[LAT];
            assign idx_out = idx_p[LAT];
        end
    endgenerate

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps every minterm into a single-output function, rebuilds its truth table,
// counts the onset and compares the table against an expected one.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int  NUM_VARS = NUM_VARS_DEFAULT,
    parameter int  LAT      = 0,
    localparam int TT_BITS  = 2 ** NUM_VARS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [NUM_VARS-1:0] x_out,
    input  logic                f_in,
    input  logic [TT_BITS-1:0]  exp_tt,
    output logic                busy,
    output logic [TT_BITS-1:0]  tt_out,
    output logic [NUM_VARS:0]   onset,
    output logic                match,
    output logic                tt_valid,
    input  logic                tt_ready
);

    localparam logic [NUM_VARS-1:0] LAST_IDX = NUM_VARS'(TT_BITS - 1);

    state_t              state_q, state_d;
    logic [NUM_VARS-1:0] x_q;
    logic                vld_d;
    logic [NUM_VARS-1:0] idx_d;
    logic [TT_BITS-1:0]  tt_q, tt_cap;
    logic [NUM_VARS:0]   onset_q, onset_cap;
    logic                match_q;
    logic                done_entry;

    tt_lat_pipe #(
        .LAT   (LAT),
        .IDX_W (NUM_VARS)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (abort),
        .vld_p0  (state_q == SWEEP),
        .idx_p0  (x_q),
        .vld_out (vld_d),
        .idx_out (idx_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = SWEEP;
                SWEEP:   if (x_q == LAST_IDX) state_d = (LAT > 0) ? DRAIN : DONE;
                DRAIN:   if (vld_d && idx_d == LAST_IDX) state_d = DONE;
                DONE:    if (tt_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Table/onset including the sample landing at this edge; match must see it too.
    always_comb begin
        tt_cap    = tt_q;
        onset_cap = onset_q;
        if (vld_d) begin
            tt_cap[idx_d] = f_in;
            onset_cap     = onset_q + {{NUM_VARS{1'b0}}, f_in};
        end
    end

    assign done_entry = (state_d == DONE) && (state_q != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            tt_q    <= '0;
            onset_q <= '0;
            match_q <= 1'b0;
        end else if (!abort) begin
            if (state_q == IDLE && start) begin
                x_q     <= '0;
                tt_q    <= '0;
                onset_q <= '0;
            end else begin
                if (vld_d) begin
                    tt_q    <= tt_cap;
                    onset_q <= onset_cap;
                end
                if (state_q == SWEEP && x_q != LAST_IDX) x_q <= x_q + NUM_VARS'(1);
                if (done_entry) match_q <= (tt_cap == exp_tt);
            end
        end
    end

    assign x_out    = x_q;
    assign tt_out   = tt_q;
    assign onset    = onset_q;
    assign match    = match_q;
    assign busy     = (state_q == SWEEP) || (state_q == DRAIN);
    assign tt_valid = (state_q == DONE);

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: a LAT=0 instance driven from a vector table and a
// LAT=2 instance fed through a registered majority model, both scoreboarded.
module tb_tt_sweep_capture;

    localparam int TB = 128;

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   onset;
        logic         match;
        int           lat;
    } exp_t;

    typedef struct {
        logic [2:0]   mode;
        logic [127:0] exp_tt;
        logic [127:0] tt;
        logic [7:0]   onset;
        logic         match;
        logic         stall;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic         rst_n;
    logic         start0, abort0, f_in0, tt_ready0, busy0, match0, tt_valid0;
    logic [6:0]   x_out0;
    logic [127:0] exp_tt0, tt_out0;
    logic [7:0]   onset0;
    logic [2:0]   mode0;

    logic         start2, abort2, f_in2, tt_ready2, busy2, match2, tt_valid2;
    logic [6:0]   x_out2;
    logic [127:0] exp_tt2, tt_out2;
    logic [7:0]   onset2;
    logic         mode2;
    logic         f2_p1, f2_p2;

    exp_t sb0[$];
    exp_t sb2[$];
    vec_t vecs[5];

    tt_sweep_capture #(.NUM_VARS(7), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .x_out(x_out0),
        .f_in(f_in0), .exp_tt(exp_tt0), .busy(busy0), .tt_out(tt_out0),
        .onset(onset0), .match(match0), .tt_valid(tt_valid0), .tt_ready(tt_ready0)
    );

    tt_sweep_capture #(.NUM_VARS(7), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .x_out(x_out2),
        .f_in(f_in2), .exp_tt(exp_tt2), .busy(busy2), .tt_out(tt_out2),
        .onset(onset2), .match(match2), .tt_valid(tt_valid2), .tt_ready(tt_ready2)
    );

    always_comb begin
        case (mode0)
            3'd0:    f_in0 = x_out0[0];
            3'd1:    f_in0 = 1'b0;
            3'd2:    f_in0 = 1'b1;
            3'd3:    f_in0 = x_out0[6];
            default: f_in0 = x_out0[3];
        endcase
    end

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Two-cycle registered function model for the LAT=2 instance.
    always @(posedge clk) begin
        f2_p1 <= mode2 ? 1'b1 : maj3(x_out2[0], x_out2[2], x_out2[5]);
        f2_p2 <= f2_p1;
    end
    assign f_in2 = f2_p2;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        chk(name, 128'(act), 128'(req));
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   s;
        bit   got;
        mode0   = v.mode;
        exp_tt0 = v.exp_tt;
        sb0.push_back('{v.tt, v.onset, v.match, TB});
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        s = cyc;
        chk1("busy0_after_start", busy0, 1'b1);
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (tt_valid0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        e = sb0.pop_front();
        if (!got) begin
            chk1("tt_valid0_timeout", 1'b0, 1'b1);
            return;
        end
        chk("latency0", 128'(cyc - s), 128'(e.lat));
        chk("tt_out0", tt_out0, e.tt);
        chk("onset0", 128'(onset0), 128'(e.onset));
        chk1("match0", match0, e.match);
        chk1("busy0_in_done", busy0, 1'b0);
        if (v.stall) begin
            for (int j = 0; j < 20; j++) begin
                start0 = (j % 4 == 1);
                @(negedge clk);
                chk1("stall_tt_valid0", tt_valid0, 1'b1);
                chk("stall_tt_out0", tt_out0, e.tt);
                chk("stall_onset0", 128'(onset0), 128'(e.onset));
            end
            start0 = 1'b1;
        end
        tt_ready0 = 1'b1;
        @(negedge clk);
        tt_ready0 = 1'b0;
        start0    = 1'b0;
        chk1("tt_valid0_after_ready", tt_valid0, 1'b0);
        chk1("busy0_after_ready", busy0, 1'b0);
        @(negedge clk);
        chk1("busy0_stays_idle", busy0, 1'b0);
    endtask

    task automatic sweep2(input logic m, input logic [127:0] ett, input exp_t exp_in);
        exp_t e;
        int   s;
        bit   got;
        mode2   = m;
        exp_tt2 = ett;
        sb2.push_back(exp_in);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        s = cyc;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (tt_valid2) begin
                got = 1'b1;
                break;
            end
            if (cyc - s == 128 || cyc - s == 129) begin
                chk("drain_x_out2", 128'(x_out2), 128'(127));
                chk1("drain_busy2", busy2, 1'b1);
            end
            @(negedge clk);
        end
        e = sb2.pop_front();
        if (!got) begin
            chk1("tt_valid2_timeout", 1'b0, 1'b1);
            return;
        end
        chk("latency2", 128'(cyc - s), 128'(e.lat));
        chk("tt_out2", tt_out2, e.tt);
        chk("onset2", 128'(onset2), 128'(e.onset));
        chk1("match2", match2, e.match);
        tt_ready2 = 1'b1;
        @(negedge clk);
        tt_ready2 = 1'b0;
        chk1("tt_valid2_after_ready", tt_valid2, 1'b0);
    endtask

    initial begin
        logic [127:0] pat_a, pat_x6, pat_x3, maj_ref, ones;
        bit           hit;
        rst_n = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; tt_ready0 = 1'b0; exp_tt0 = '0; mode0 = 3'd0;
        start2 = 1'b0; abort2 = 1'b0; tt_ready2 = 1'b0; exp_tt2 = '0; mode2 = 1'b0;

        pat_a  = {32{4'hA}};
        pat_x6 = {{64{1'b1}}, {64{1'b0}}};
        pat_x3 = {8{16'hFF00}};
        ones   = {128{1'b1}};
        maj_ref = '0;
        for (int i = 0; i < TB; i++) maj_ref[i] = maj3(i[0], i[2], i[5]);

        repeat (3) @(negedge clk);
        chk("rst_x_out0", 128'(x_out0), 128'(0));
        chk("rst_tt_out0", tt_out0, 128'(0));
        chk("rst_onset0", 128'(onset0), 128'(0));
        chk1("rst_match0", match0, 1'b0);
        chk1("rst_tt_valid0", tt_valid0, 1'b0);
        chk1("rst_busy0", busy0, 1'b0);
        chk1("rst_busy2", busy2, 1'b0);
        chk1("rst_tt_valid2", tt_valid2, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{3'd0, pat_a,  pat_a,  8'd64,  1'b1, 1'b0};
        vecs[1] = '{3'd1, '0,     '0,     8'd0,   1'b1, 1'b0};
        vecs[2] = '{3'd2, '0,     ones,   8'd128, 1'b0, 1'b0};
        vecs[3] = '{3'd3, pat_a,  pat_x6, 8'd64,  1'b0, 1'b1};
        vecs[4] = '{3'd4, pat_x3, pat_x3, 8'd64,  1'b1, 1'b0};
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // LAT=2 majority sweep, including the DRAIN hold of the last minterm.
        sweep2(1'b0, maj_ref, '{maj_ref, 8'd64, 1'b1, TB + 2});

        // Reset in the middle of an all-ones sweep, then a clean x6 sweep.
        mode0 = 3'd2;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (x_out0 == 7'd50) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk1("reach_minterm50", hit, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_x_out0", 128'(x_out0), 128'(0));
        chk("midrst_tt_out0", tt_out0, 128'(0));
        chk("midrst_onset0", 128'(onset0), 128'(0));
        chk1("midrst_match0", match0, 1'b0);
        chk1("midrst_busy0", busy0, 1'b0);
        chk1("midrst_tt_valid0", tt_valid0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec('{3'd3, pat_x6, pat_x6, 8'd64, 1'b1, 1'b0});

        // Abort at minterm 90 on the LAT=2 instance, restart at once with all-ones.
        mode2 = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (x_out2 == 7'd90) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk1("reach_minterm90", hit, 1'b1);
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        chk1("abort_busy2", busy2, 1'b0);
        chk1("abort_tt_valid2", tt_valid2, 1'b0);
        sweep2(1'b1, ones, '{ones, 8'd128, 1'b1, TB + 2});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
